// File: rtl/sram_controller_if.sv
// ----------------------------------------------------------------------------
// sram_controller_if
//   Bundles the CPU-side request/response signals and the external SRAM
//   pins of sram_controller into one interface.
//
//   CPU side : rd_en, wr_en, address, writeData -> controller
//              readData, ready                   <- controller
//   SRAM side: SRAM_ADDR, SRAM_WE_N, sram_dq_out, sram_dq_oe <- controller
//              sram_dq_in                                    -> controller
//
//   Handshake: a request (rd_en or wr_en) is taken only while the controller
//   is idle. From the cycle it is taken, ready stays low until the access
//   completes. ready then returns high for exactly one cycle, in which
//   readData is valid for a load. The requester must hold its request
//   stable until it sees ready high.
//
//   modport slave  : the controller
//   modport master : the pipeline / system side, including the SRAM data
//                    return path
// ----------------------------------------------------------------------------
interface sram_controller_if #(
    parameter int SRAM_AW = 18
);
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        address;
    logic [31:0]        writeData;
    logic [31:0]        readData;
    logic               ready;
    logic [SRAM_AW-1:0] SRAM_ADDR;
    logic               SRAM_WE_N;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;

    modport slave (
        input  rd_en, wr_en, address, writeData, sram_dq_in,
        output readData, ready, SRAM_ADDR, SRAM_WE_N, sram_dq_out, sram_dq_oe
    );

    modport master (
        output rd_en, wr_en, address, writeData, sram_dq_in,
        input  readData, ready, SRAM_ADDR, SRAM_WE_N, sram_dq_out, sram_dq_oe
    );
endinterface

// File: rtl/sram_controller.sv
// ----------------------------------------------------------------------------
// sram_controller
//   Sequences a 16-bit asynchronous SRAM for the MEM stage. Each 32-bit
//   load/store becomes a low half-word access, a high half-word access and
//   then WAIT_CYCLES idle cycles before the one-cycle DONE state. ready is
//   low for the whole access so the top level can freeze the pipeline.
//
//   Ports:
//     clk          system clock
//     rst          synchronous, active-high reset
//     bus          sram_controller_if.slave (CPU request/response + SRAM pins)
//     o_dbg_state  current FSM state (IDLE=0, S_LO=1, S_HI=2, S_WAIT=3,
//                  S_DONE=4)
//
//   Parameters:
//     BASE_ADDR    byte address subtracted from the CPU address
//     SRAM_AW      SRAM half-word address width
//     WAIT_CYCLES  settle cycles after the high half-word access (1..15)
// ----------------------------------------------------------------------------
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       bus,
    output logic [2:0]             o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] LP_WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic               r_op_wr;
    logic [SRAM_AW-2:0] r_base;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;

    logic               w_req;
    logic [31:0]        w_offset;
    logic [SRAM_AW-1:0] w_hw_lo;
    logic [SRAM_AW-1:0] w_hw_hi;

    assign w_req    = bus.rd_en | bus.wr_en;
    // Upper bits fall off when sliced into r_base, so addresses (including
    // those below BASE_ADDR) wrap modulo the SRAM size.
    assign w_offset = bus.address - 32'(BASE_ADDR);
    assign w_hw_lo  = {r_base, 1'b0};
    assign w_hw_hi  = {r_base, 1'b1};

    assign bus.readData = r_rdata;
    assign o_dbg_state  = r_state;

    // State register and datapath latches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op_wr <= 1'b0;
            r_base  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        // A store wins when both requests are present.
                        r_op_wr <= bus.wr_en;
                        r_base  <= w_offset[SRAM_AW:2];
                        r_wdata <= bus.writeData;
                    end
                end
                S_LO: begin
                    if (!r_op_wr) r_rdata[15:0] <= bus.sram_dq_in;
                end
                S_HI: begin
                    if (!r_op_wr) r_rdata[31:16] <= bus.sram_dq_in;
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Next state and SRAM/pipeline outputs
    always_comb begin
        w_next          = r_state;
        bus.ready       = 1'b0;
        bus.SRAM_ADDR   = '0;
        bus.SRAM_WE_N   = 1'b1;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_dq_out = '0;
        case (r_state)
            IDLE: begin
                // Combinational so the freeze starts in the request cycle.
                bus.ready = ~w_req;
                if (w_req) w_next = S_LO;
            end
            S_LO: begin
                bus.SRAM_ADDR = w_hw_lo;
                if (r_op_wr) begin
                    bus.SRAM_WE_N   = 1'b0;
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_dq_out = r_wdata[15:0];
                end
                w_next = S_HI;
            end
            S_HI: begin
                bus.SRAM_ADDR = w_hw_hi;
                if (r_op_wr) begin
                    bus.SRAM_WE_N   = 1'b0;
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_dq_out = r_wdata[31:16];
                end
                w_next = S_WAIT;
            end
            S_WAIT: begin
                bus.SRAM_ADDR = w_hw_hi;
                if (r_cnt == LP_WAIT_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                bus.SRAM_ADDR = w_hw_hi;
                bus.ready     = 1'b1;
                // Pipeline advances on this edge; a still-present request
                // belongs to the old instruction and is not re-accepted.
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences the external 16-bit asynchronous SRAM for the MEM stage of the 5-stage ARM pipeline.
- Each 32-bit load or store is split into two half-word SRAM accesses, followed by a programmable settle wait.
- While an access is in progress, `ready` is held low so the top level can freeze the pipeline: PC, all stage registers and the hazard path.
- Sits between the EXE_stage_reg outputs (mem_r_en, mem_w_en, ALU result as address, Val_Rm as store data) and the MEM_stage_reg input (read data).

Parameters:
- BASE_ADDR, 1024: byte address subtracted from the CPU address before mapping into the SRAM.
- SRAM_AW, 18: SRAM half-word address width.
- WAIT_CYCLES, 2: extra idle cycles after the high half-word access, range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  load request from the MEM stage
- wr_en  in  1  store request from the MEM stage
- address  in  32  CPU byte address (ALU result)
- writeData  in  32  store data (Val_Rm)
- readData  out  32  load data, valid while ready=1 after a read
- ready  out  1  1 = MEM stage may advance; 0 = freeze pipeline
- SRAM_ADDR  out  SRAM_AW  SRAM half-word address
- SRAM_WE_N  out  1  SRAM write enable, active low
- sram_dq_out  out  16  data driven to the SRAM DQ bus
- sram_dq_oe  out  1  1 = drive the DQ bus (top level builds the tristate)
- sram_dq_in  in  16  data sampled from the DQ bus

Behaviour:
- States: IDLE, S_LO, S_HI, S_WAIT, S_DONE.
- Reset, applied at any clock edge, including mid-transaction:
  - state=IDLE, wait counter=0, op/addr/data latches=0, readData=0.
  - Outputs return to their idle values: SRAM_WE_N=1, sram_dq_oe=0, SRAM_ADDR=0, sram_dq_out=0.
  - ready=1 if no request is present.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational, so the freeze asserts in the same cycle as the request.
  - On a request:
    - Latch op: write if wr_en=1, else read. Write wins when both are asserted.
    - Latch base = (address - BASE_ADDR) with bits [1:0] dropped.
    - Latch writeData.
    - Go to S_LO.
- Half-word address mapping:
  - hw_lo = {base[SRAM_AW-2:0], 1'b0}; hw_hi = hw_lo | 1.
  - Upper bits are truncated, so addresses wrap modulo 2^SRAM_AW half-words.
  - Addresses below BASE_ADDR wrap the same way; no error is raised.
- S_LO:
  - SRAM_ADDR=hw_lo.
  - Write: SRAM_WE_N=0, sram_dq_oe=1, sram_dq_out=wdata[15:0].
  - Read: SRAM_WE_N=1, sram_dq_oe=0; rdata[15:0] <= sram_dq_in at the clock edge.
  - Next state: S_HI.
- S_HI: same as S_LO using hw_hi and bits [31:16]. Next state: S_WAIT, counter cleared.
- S_WAIT:
  - SRAM_WE_N=1, sram_dq_oe=0, SRAM_ADDR held at hw_hi.
  - Counter increments each cycle; go to S_DONE when counter = WAIT_CYCLES-1.
- S_DONE:
  - ready=1; readData shows the assembled rdata. After a write, readData holds the last read value.
  - Next state: IDLE unconditionally. The pipeline advances on this edge, so a request still asserted here is not re-accepted.
- Latency, for a request accepted in cycle t:
  - DONE is in cycle t+3+WAIT_CYCLES.
  - ready is low for 3+WAIT_CYCLES cycles (5 at the default).
  - A back-to-back request is accepted in IDLE at cycle t+4+WAIT_CYCLES.
- Request inputs are ignored outside IDLE. Deasserting rd_en/wr_en mid-transaction does not abort it; the latched op completes.
- ready is 0 in S_LO, S_HI and S_WAIT.
- SRAM_WE_N is never low outside S_LO/S_HI of a write.
- sram_dq_oe equals ~SRAM_WE_N at all times.

Test Plan:
1. Store then load, default parameters, with a behavioural SRAM model on the bench:
   - wr_en=1, address=1024, writeData=0xDEADBEEF. Expect: SRAM hw0=0xBEEF, hw1=0xDEAD; ready low exactly 5 cycles.
   - Then rd_en=1 at address 1024. Expect readData=0xDEADBEEF while ready=1 in S_DONE.
2. Offset address: wr_en=1, address=1036, writeData=0x12345678. Expect SRAM hw6=0x5678, hw7=0x1234; hw4 and hw5 unchanged.
3. rd_en and wr_en asserted together at address 1028 with data 0xA5A5_5A5A. Expect a write to hw2/hw3, SRAM_WE_N pulsed low for 2 cycles, readData unchanged.
4. Request deasserted in S_HI: the transaction still completes with ready returning in cycle t+5. A request held through S_DONE produces exactly one transaction; the next is accepted only in IDLE.
5. Reset asserted in S_WAIT of a read:
   - Next cycle: IDLE, readData=0, SRAM_WE_N=1, sram_dq_oe=0.
   - ready=1 with no request; ready=0 immediately if a request is present.
6. Wrap: address = 1024 + 4*2^17 with writeData=0x0000FFFF writes hw0/hw1. Verify by reading back at address 1024: readData=0x0000FFFF.
